// File: rtl/alu_exec_stage.sv
// Execute stage of the 16-bit pipeline: ID/EX register, combinational ALU, EX/MEM register.
// Supports a global stall (hold both registers) and a flush (bubble into ID/EX).
module alu_exec_stage #(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [15:0]           id_A,
    input  logic [15:0]           id_B,
    input  logic [15:0]           id_imm,
    input  logic [3:0]            id_Op,
    input  logic                  id_invA,
    input  logic                  id_invB,
    input  logic                  id_Cin,
    input  logic                  id_sign,
    input  logic                  id_alusrc,
    input  logic [REG_ADDR_W-1:0] id_wr_reg,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  mem_valid,
    output logic [15:0]           mem_result,
    output logic                  mem_zero,
    output logic                  mem_neg,
    output logic                  mem_ofl,
    output logic                  mem_cout,
    output logic [REG_ADDR_W-1:0] mem_wr_reg,
    output logic                  ex_valid
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SHAMT_W = 4;

    localparam logic [3:0] OP_ROL  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_ROR  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_BTR  = 4'b1000;
    localparam logic [3:0] OP_PASB = 4'b1001;
    localparam logic [3:0] OP_SLBI = 4'b1010;

    // ID/EX register
    logic                  r_ex_valid;
    logic [DATA_W-1:0]     r_ex_a;
    logic [DATA_W-1:0]     r_ex_b;
    logic [DATA_W-1:0]     r_ex_imm;
    logic [3:0]            r_ex_op;
    logic                  r_ex_inva;
    logic                  r_ex_invb;
    logic                  r_ex_cin;
    logic                  r_ex_sign;
    logic                  r_ex_alusrc;
    logic [REG_ADDR_W-1:0] r_ex_wr_reg;

    // EX/MEM register
    logic                  r_mem_valid;
    logic [DATA_W-1:0]     r_mem_result;
    logic                  r_mem_zero;
    logic                  r_mem_neg;
    logic                  r_mem_ofl;
    logic                  r_mem_cout;
    logic [REG_ADDR_W-1:0] r_mem_wr_reg;

    // ALU datapath
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_bsel;
    logic [DATA_W-1:0]  w_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic [SHAMT_W:0]   w_rshamt;
    logic [DATA_W-1:0]  w_rotl;
    logic [DATA_W-1:0]  w_rotr;
    logic [DATA_W-1:0]  w_rev;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W-1:0]  w_result;
    logic               w_zero;
    logic               w_neg;
    logic               w_ofl;
    logic               w_cout;

    assign w_a      = r_ex_inva ? ~r_ex_a : r_ex_a;
    assign w_bsel   = r_ex_alusrc ? r_ex_imm : r_ex_b;
    assign w_b      = r_ex_invb ? ~w_bsel : w_bsel;
    assign w_shamt  = w_b[SHAMT_W-1:0];
    // Complementary amount is 16 when shamt is 0, which shifts everything out.
    assign w_rshamt = 5'(DATA_W) - {1'b0, w_shamt};
    assign w_rotl   = (w_a << w_shamt) | (w_a >> w_rshamt);
    assign w_rotr   = (w_a >> w_shamt) | (w_a << w_rshamt);
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b} + 17'(r_ex_cin);

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            w_rev[i] = w_a[int'(DATA_W) - 1 - i];
        end
    end

    always_comb begin
        w_result = w_a;
        w_cout   = 1'b0;
        w_ofl    = 1'b0;
        case (r_ex_op)
            OP_ROL:  w_result = w_rotl;
            OP_SLL:  w_result = w_a << w_shamt;
            OP_ROR:  w_result = w_rotr;
            OP_SRL:  w_result = w_a >> w_shamt;
            OP_ADD: begin
                w_result = w_sum[DATA_W-1:0];
                w_cout   = w_sum[DATA_W];
                w_ofl    = r_ex_sign ? ((w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                                        (w_sum[DATA_W-1] != w_a[DATA_W-1]))
                                     : w_sum[DATA_W];
            end
            OP_OR:   w_result = w_a | w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_AND:  w_result = w_a & w_b;
            OP_BTR:  w_result = w_rev;
            OP_PASB: w_result = w_b;
            OP_SLBI: w_result = {w_a[7:0], w_b[7:0]};
            default: w_result = w_a;
        endcase
        w_zero = (w_result == '0);
        w_neg  = w_result[DATA_W-1];
    end

    // Flush takes priority over stall so a held slot can still be turned into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_imm    <= '0;
            r_ex_op     <= '0;
            r_ex_inva   <= 1'b0;
            r_ex_invb   <= 1'b0;
            r_ex_cin    <= 1'b0;
            r_ex_sign   <= 1'b0;
            r_ex_alusrc <= 1'b0;
            r_ex_wr_reg <= '0;
        end else if (flush) begin
            r_ex_valid  <= 1'b0;
        end else if (!stall) begin
            r_ex_valid  <= id_valid;
            r_ex_a      <= id_A;
            r_ex_b      <= id_B;
            r_ex_imm    <= id_imm;
            r_ex_op     <= id_Op;
            r_ex_inva   <= id_invA;
            r_ex_invb   <= id_invB;
            r_ex_cin    <= id_Cin;
            r_ex_sign   <= id_sign;
            r_ex_alusrc <= id_alusrc;
            r_ex_wr_reg <= id_wr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid  <= 1'b0;
            r_mem_result <= '0;
            r_mem_zero   <= 1'b0;
            r_mem_neg    <= 1'b0;
            r_mem_ofl    <= 1'b0;
            r_mem_cout   <= 1'b0;
            r_mem_wr_reg <= '0;
        end else if (!stall) begin
            r_mem_valid  <= r_ex_valid;
            r_mem_result <= w_result;
            r_mem_zero   <= w_zero;
            r_mem_neg    <= w_neg;
            r_mem_ofl    <= w_ofl;
            r_mem_cout   <= w_cout;
            r_mem_wr_reg <= r_ex_wr_reg;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign mem_valid  = r_mem_valid;
    assign mem_result = r_mem_result;
    assign mem_zero   = r_mem_zero;
    assign mem_neg    = r_mem_neg;
    assign mem_ofl    = r_mem_ofl;
    assign mem_cout   = r_mem_cout;
    assign mem_wr_reg = r_mem_wr_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, pipeline corner sequences,
// and randomized traffic against an arithmetic reference model of the two-stage slice.
module tb_alu_exec_stage;

    localparam int unsigned RW = 3;

    typedef struct {
        logic          valid;
        logic [15:0]   a, b, imm;
        logic [3:0]    op;
        logic          inva, invb, cin, sign, alusrc;
        logic [RW-1:0] wr;
    } instr_t;

    typedef struct {
        logic          valid;
        logic [15:0]   res;
        logic          z, n, o, c;
        logic [RW-1:0] wr;
    } mem_t;

    typedef struct {
        instr_t      in;
        logic [15:0] res;
        logic        z, n, o, c;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [15:0]   id_A, id_B, id_imm;
    logic [3:0]    id_Op;
    logic          id_invA, id_invB, id_Cin, id_sign, id_alusrc;
    logic [RW-1:0] id_wr_reg;
    logic          stall, flush;
    logic          mem_valid;
    logic [15:0]   mem_result;
    logic          mem_zero, mem_neg, mem_ofl, mem_cout;
    logic [RW-1:0] mem_wr_reg;
    logic          ex_valid;

    int checks = 0;
    int errors = 0;

    instr_t m_ex;
    mem_t   m_mem;

    always #5 clk = ~clk;

    alu_exec_stage #(.REG_ADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_A(id_A), .id_B(id_B), .id_imm(id_imm), .id_Op(id_Op),
        .id_invA(id_invA), .id_invB(id_invB), .id_Cin(id_Cin), .id_sign(id_sign),
        .id_alusrc(id_alusrc), .id_wr_reg(id_wr_reg),
        .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_zero(mem_zero),
        .mem_neg(mem_neg), .mem_ofl(mem_ofl), .mem_cout(mem_cout),
        .mem_wr_reg(mem_wr_reg), .ex_valid(ex_valid)
    );

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU computed from the operation definitions with integer arithmetic.
    function automatic mem_t alu_ref(input instr_t x);
        mem_t        m;
        logic [15:0] a, b, r;
        int          n, s, ss;
        a = x.inva ? ~x.a : x.a;
        b = x.alusrc ? x.imm : x.b;
        if (x.invb) b = ~b;
        n = int'(b) % 16;
        r = a;
        m.c = 1'b0;
        m.o = 1'b0;
        case (x.op)
            4'd0: repeat (n) r = {r[14:0], r[15]};
            4'd1: r = 16'(int'(a) * (1 << n));
            4'd2: repeat (n) r = {r[0], r[15:1]};
            4'd3: r = 16'(int'(a) / (1 << n));
            4'd4: begin
                s   = int'(a) + int'(b) + int'(x.cin);
                ss  = int'($signed(a)) + int'($signed(b)) + int'(x.cin);
                r   = 16'(s);
                m.c = (s > 65535);
                m.o = x.sign ? ((ss > 32767) || (ss < -32768)) : m.c;
            end
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = a & b;
            4'd8: for (int i = 0; i < 16; i++) r[i] = a[15 - i];
            4'd9: r = b;
            4'd10: r = 16'(int'(a) * 256 + int'(b) % 256);
            default: r = a;
        endcase
        m.res   = r;
        m.z     = (r == 16'h0000);
        m.n     = r[15];
        m.valid = x.valid;
        m.wr    = x.wr;
        return m;
    endfunction

    function automatic instr_t mki(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] imm, input logic [3:0] op,
                                   input logic ia, input logic ib, input logic ci,
                                   input logic sg, input logic as, input logic [RW-1:0] wr);
        instr_t x;
        x.valid = 1'b1; x.a = a; x.b = b; x.imm = imm; x.op = op;
        x.inva = ia; x.invb = ib; x.cin = ci; x.sign = sg; x.alusrc = as; x.wr = wr;
        return x;
    endfunction

    function automatic instr_t idle_instr();
        instr_t x;
        x = mki(16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        x.valid = 1'b0;
        return x;
    endfunction

    function automatic vec_t mkv(input instr_t i, input logic [15:0] r,
                                 input logic z, input logic n, input logic o, input logic c);
        vec_t v;
        v.in = i; v.res = r; v.z = z; v.n = n; v.o = o; v.c = c;
        return v;
    endfunction

    task automatic model_reset();
        m_ex  = idle_instr();
        m_mem = '{valid: 1'b0, res: 16'h0, z: 1'b0, n: 1'b0, o: 1'b0, c: 1'b0, wr: '0};
    endtask

    // Present one cycle of inputs, advance the model over the edge, then compare.
    task automatic drive(input instr_t x, input logic st, input logic fl);
        id_valid = x.valid; id_A = x.a; id_B = x.b; id_imm = x.imm; id_Op = x.op;
        id_invA = x.inva; id_invB = x.invb; id_Cin = x.cin; id_sign = x.sign;
        id_alusrc = x.alusrc; id_wr_reg = x.wr; stall = st; flush = fl;
        @(posedge clk);
        if (!st) m_mem = alu_ref(m_ex);
        if (fl) m_ex.valid = 1'b0;
        else if (!st) m_ex = x;
        #1;
        chk1("model_ex_valid", ex_valid, m_ex.valid);
        chk1("model_mem_valid", mem_valid, m_mem.valid);
        if (m_mem.valid) begin
            chk16("model_result", mem_result, m_mem.res);
            chk1("model_zero", mem_zero, m_mem.z);
            chk1("model_neg", mem_neg, m_mem.n);
            chk1("model_ofl", mem_ofl, m_mem.o);
            chk1("model_cout", mem_cout, m_mem.c);
            chk16("model_wr_reg", 16'(mem_wr_reg), 16'(m_mem.wr));
        end
    endtask

    vec_t        tbl[14];
    instr_t      seq[3];
    logic [15:0] stall_exp[5];
    instr_t      rx;

    initial begin
        // a, b, imm, op, invA, invB, Cin, sign, alusrc, wr -> result, zero, neg, ofl, cout
        tbl[0]  = mkv(mki(16'h7FFF, 16'h0001, 16'h0000, 4'h4, 0, 0, 0, 1, 0, 3'd1), 16'h8000, 0, 1, 1, 0);
        tbl[1]  = mkv(mki(16'h0005, 16'h0000, 16'h0003, 4'h4, 1, 0, 1, 0, 1, 3'd2), 16'hFFFE, 0, 1, 0, 0);
        tbl[2]  = mkv(mki(16'h8001, 16'h0001, 16'h0000, 4'h0, 0, 0, 0, 0, 0, 3'd3), 16'h0003, 0, 0, 0, 0);
        tbl[3]  = mkv(mki(16'h8000, 16'h000F, 16'h0000, 4'h3, 0, 0, 0, 0, 0, 3'd4), 16'h0001, 0, 0, 0, 0);
        tbl[4]  = mkv(mki(16'h0012, 16'h0000, 16'h0034, 4'hA, 0, 0, 0, 0, 1, 3'd5), 16'h1234, 0, 0, 0, 0);
        tbl[5]  = mkv(mki(16'h0001, 16'h0000, 16'h0000, 4'h8, 0, 0, 0, 0, 0, 3'd6), 16'h8000, 0, 1, 0, 0);
        tbl[6]  = mkv(mki(16'hABCD, 16'h0000, 16'h0000, 4'h2, 0, 0, 0, 0, 0, 3'd7), 16'hABCD, 0, 1, 0, 0);
        tbl[7]  = mkv(mki(16'hABCD, 16'hABCD, 16'h0000, 4'h6, 0, 0, 0, 0, 0, 3'd0), 16'h0000, 1, 0, 0, 0);
        tbl[8]  = mkv(mki(16'hFFFF, 16'h00F0, 16'h0000, 4'h7, 0, 0, 0, 0, 0, 3'd1), 16'h00F0, 0, 0, 0, 0);
        tbl[9]  = mkv(mki(16'hFFFF, 16'h0001, 16'h0000, 4'h4, 0, 0, 0, 0, 0, 3'd2), 16'h0000, 1, 0, 1, 1);
        tbl[10] = mkv(mki(16'h0001, 16'h0010, 16'h0000, 4'h1, 0, 0, 0, 0, 0, 3'd3), 16'h0001, 0, 0, 0, 0);
        tbl[11] = mkv(mki(16'h0000, 16'h00FF, 16'h0000, 4'h9, 0, 1, 0, 0, 0, 3'd4), 16'hFF00, 0, 1, 0, 0);
        tbl[12] = mkv(mki(16'h1234, 16'h5555, 16'h0000, 4'hC, 0, 0, 0, 0, 0, 3'd5), 16'h1234, 0, 0, 0, 0);
        tbl[13] = mkv(mki(16'h0F00, 16'h00F0, 16'h0000, 4'h5, 0, 0, 0, 0, 0, 3'd6), 16'h0FF0, 0, 0, 0, 0);

        seq[0] = mki(16'h1111, 16'h0, 16'h0, 4'hF, 0, 0, 0, 0, 0, 3'd1);
        seq[1] = mki(16'h2222, 16'h0, 16'h0, 4'hF, 0, 0, 0, 0, 0, 3'd2);
        seq[2] = mki(16'h3333, 16'h0, 16'h0, 4'hF, 0, 0, 0, 0, 0, 3'd3);
        stall_exp[0] = 16'h1111; stall_exp[1] = 16'h1111; stall_exp[2] = 16'h1111;
        stall_exp[3] = 16'h2222; stall_exp[4] = 16'h3333;

        // Power-on reset
        rst_n = 1'b0;
        id_valid = 1'b0; id_A = '0; id_B = '0; id_imm = '0; id_Op = '0;
        id_invA = 1'b0; id_invB = 1'b0; id_Cin = 1'b0; id_sign = 1'b0; id_alusrc = 1'b0;
        id_wr_reg = '0; stall = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        chk1("rst_ex_valid", ex_valid, 1'b0);
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk16("rst_mem_result", mem_result, 16'h0000);
        chk1("rst_zero", mem_zero, 1'b0);
        chk1("rst_neg", mem_neg, 1'b0);
        chk1("rst_ofl", mem_ofl, 1'b0);
        chk1("rst_cout", mem_cout, 1'b0);
        chk16("rst_wr_reg", 16'(mem_wr_reg), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors back-to-back; entry i-1 lands on mem_* while entry i is issued.
        for (int i = 0; i <= 14; i++) begin
            drive((i < 14) ? tbl[i].in : idle_instr(), 1'b0, 1'b0);
            if (i >= 1) begin
                chk1("tbl_valid", mem_valid, 1'b1);
                chk16($sformatf("tbl%0d_result", i - 1), mem_result, tbl[i - 1].res);
                chk1($sformatf("tbl%0d_zero", i - 1), mem_zero, tbl[i - 1].z);
                chk1($sformatf("tbl%0d_neg", i - 1), mem_neg, tbl[i - 1].n);
                chk1($sformatf("tbl%0d_ofl", i - 1), mem_ofl, tbl[i - 1].o);
                chk1($sformatf("tbl%0d_cout", i - 1), mem_cout, tbl[i - 1].c);
                chk16($sformatf("tbl%0d_wr", i - 1), 16'(mem_wr_reg), 16'(tbl[i - 1].in.wr));
            end
        end

        // Stall two cycles while I2 sits in ID/EX: mem shows I1,I1,I1,I2,I3.
        drive(seq[0], 1'b0, 1'b0);
        drive(seq[1], 1'b0, 1'b0);
        chk16("stall_seq0", mem_result, stall_exp[0]);
        drive(seq[2], 1'b1, 1'b0);
        chk16("stall_seq1", mem_result, stall_exp[1]);
        drive(seq[2], 1'b1, 1'b0);
        chk16("stall_seq2", mem_result, stall_exp[2]);
        chk1("stall_ex_held", ex_valid, 1'b1);
        drive(seq[2], 1'b0, 1'b0);
        chk16("stall_seq3", mem_result, stall_exp[3]);
        drive(idle_instr(), 1'b0, 1'b0);
        chk16("stall_seq4", mem_result, stall_exp[4]);
        chk1("stall_seq4_valid", mem_valid, 1'b1);

        // Flush during I2 capture leaves a bubble in I2's slot.
        drive(seq[0], 1'b0, 1'b0);
        drive(seq[1], 1'b0, 1'b1);
        chk16("flush_i1", mem_result, 16'h1111);
        chk1("flush_ex_bubble", ex_valid, 1'b0);
        drive(seq[2], 1'b0, 1'b0);
        chk1("flush_slot_invalid", mem_valid, 1'b0);
        drive(idle_instr(), 1'b0, 1'b0);
        chk16("flush_i3", mem_result, 16'h3333);
        chk1("flush_i3_valid", mem_valid, 1'b1);

        // Flush together with stall: ID/EX bubbles, EX/MEM holds, bubble follows on release.
        drive(seq[0], 1'b0, 1'b0);
        drive(seq[1], 1'b0, 1'b0);
        drive(seq[2], 1'b1, 1'b1);
        chk1("fs_ex_bubble", ex_valid, 1'b0);
        chk16("fs_mem_held", mem_result, 16'h1111);
        chk1("fs_mem_held_valid", mem_valid, 1'b1);
        drive(idle_instr(), 1'b0, 1'b0);
        chk1("fs_bubble_follows", mem_valid, 1'b0);

        // Asynchronous reset in the middle of a cycle with valid traffic.
        drive(seq[0], 1'b0, 1'b0);
        drive(seq[1], 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_ex_valid", ex_valid, 1'b0);
        chk1("async_rst_mem_valid", mem_valid, 1'b0);
        chk16("async_rst_result", mem_result, 16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(seq[2], 1'b0, 1'b0);
        chk1("post_rst_mem_invalid", mem_valid, 1'b0);
        drive(idle_instr(), 1'b0, 1'b0);
        chk16("post_rst_i3", mem_result, 16'h3333);

        // Randomized traffic with occasional stall/flush.
        for (int k = 0; k < 500; k++) begin
            rx = mki(16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), RW'($urandom));
            rx.valid = (($urandom % 4) != 0);
            drive(rx, ($urandom % 5) == 0, ($urandom % 10) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
